// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ packet sources share one UART transmitter byte stream.
// Optional hold timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               timeout_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               owner_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  assign owner_valid = req_valid_i[owner_q];

  // Search upward from rr_q+1 with wrap; first valid requester wins.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(rr_q) + i) % N_REQ;
      if (!win_found && req_valid_i[IDX_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    data_d      = data_q;
    last_d      = last_q;
    req_ready_o = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d       = '0;
    to_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Strobe is gated by the owner's valid so a byte is never taken from an idle source.
        if (owner_valid) begin
          req_ready_o = grant_q;
          data_d      = req_data_i[{owner_q, 3'b000} +: 8];
          last_d      = req_last_i[owner_q];
          state_d     = SEND;
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          if (last_q) begin
            rr_d    = owner_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (owner_valid) begin
          state_d = LOAD;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q + 1'b1 == CNT_W'(TIMEOUT_CYC)) begin
          rr_d    = owner_q;
          grant_d = '0;
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= IDX_W'(N_REQ - 1);
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign grant_o    = grant_q;
  assign tx_data_o  = data_q;
  assign tx_valid_o = (state_q == SEND);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester sources are byte tables, transmitter output is logged.
// Build with +define+UART_ARB_TIMEOUT_EN to exercise the hold timeout (TIMEOUT_CYC=16).
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        timeout_o;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] tx_log[$];
  int ready_cnt[4] = '{0, 0, 0, 0};
  int viol = 0;
  int to_cnt = 0;
  int g2_bytes = -1;
  logic g2_prev = 1'b0;

  // Source tables: a requester presents its next unconsumed byte
  logic [7:0] src_data[4][8];
  logic       src_last[4][8];
  int         src_len[4] = '{0, 0, 0, 0};
  int         src_base[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (!rst_i) begin
      if (tx_valid_o && tx_ready_i) tx_log.push_back(tx_data_o);
      for (int k = 0; k < 4; k++) if (req_ready_o[k]) ready_cnt[k]++;
      if ((req_ready_o & ~req_valid_i) != 4'b0) viol++;
      if (timeout_o) to_cnt++;
      if (grant_o[2] && !g2_prev) g2_bytes = tx_log.size();
      g2_prev = grant_o[2];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src(input int k);
    src_base[k] = ready_cnt[k];
    src_len[k]  = 0;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src_data[k][src_len[k]] = d;
    src_last[k][src_len[k]] = l;
    src_len[k]++;
  endtask

  task automatic drive_srcs();
    int c;
    for (int k = 0; k < 4; k++) begin
      c = ready_cnt[k] - src_base[k];
      if (c < src_len[k]) begin
        req_valid_i[k]          = 1'b1;
        req_data_i[8*k +: 8]    = src_data[k][c];
        req_last_i[k]           = src_last[k][c];
      end else begin
        req_valid_i[k]          = 1'b0;
        req_data_i[8*k +: 8]    = 8'h00;
        req_last_i[k]           = 1'b0;
      end
    end
  endtask

  task automatic run_until(input string tag, input int target, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (tx_log.size() >= target) break;
      cyc();
      drive_srcs();
    end
    check(tag, tx_log.size(), target);
  endtask

  int b;
  int r0;
  int k_to;

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; tx_ready_i = 1'b0;
    repeat (3) cyc();
    check("rst_grant", grant_o, 4'b0000);
    check("rst_ready", req_ready_o, 4'b0000);
    check("rst_txv", tx_valid_o, 1'b0);
    check("rst_txd", tx_data_o, 8'h00);
    check("rst_to", timeout_o, 1'b0);
    rst_i = 1'b0;

    // All four requesters with single-byte packets: round-robin from requester 0
    b = tx_log.size();
    for (int k = 0; k < 4; k++) begin
      clear_src(k);
      push(k, 8'hA0 + 8'(k), 1'b1);
    end
    tx_ready_i = 1'b1;
    drive_srcs();
    cyc(); drive_srcs();
    check("lat_grant", grant_o, 4'b0001);
    check("lat_ready", req_ready_o, 4'b0001);
    check("lat_txv_t1", tx_valid_o, 1'b0);
    cyc(); drive_srcs();
    check("lat_txv_t2", tx_valid_o, 1'b1);
    check("lat_txd_t2", tx_data_o, 8'hA0);
    run_until("rr_count", b + 4, 40);
    for (int k = 0; k < 4; k++) check($sformatf("rr_byte%0d", k), tx_log[b+k], 8'hA0 + 8'(k));
    cyc();
    check("rr_idle_grant", grant_o, 4'b0000);

    // Multi-byte packet from requester 1 is not interleaved with requester 2
    b = tx_log.size();
    clear_src(1); push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    clear_src(2); push(2, 8'h44, 1'b1);
    drive_srcs();
    run_until("pkt_count", b + 4, 60);
    check("pkt_b0", tx_log[b], 8'h11);
    check("pkt_b1", tx_log[b+1], 8'h22);
    check("pkt_b2", tx_log[b+2], 8'h33);
    check("pkt_b3", tx_log[b+3], 8'h44);
    check("pkt_g2_after", g2_bytes, b + 3);

    // Back-pressure: 20 stalled SEND cycles on 0x5A
    cyc(); drive_srcs();
    b = tx_log.size();
    r0 = ready_cnt[0];
    tx_ready_i = 1'b0;
    clear_src(0); push(0, 8'h5A, 1'b1);
    drive_srcs();
    cyc(); drive_srcs();
    cyc(); drive_srcs();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("stall_txv%0d", i), tx_valid_o, 1'b1);
      check($sformatf("stall_txd%0d", i), tx_data_o, 8'h5A);
      cyc(); drive_srcs();
    end
    check("stall_nolog", tx_log.size(), b);
    tx_ready_i = 1'b1;
    run_until("stall_done", b + 1, 10);
    repeat (5) begin cyc(); drive_srcs(); end
    check("stall_one_xfer", tx_log.size(), b + 1);
    check("stall_data", tx_log[b], 8'h5A);
    check("stall_one_ready", ready_cnt[0] - r0, 1);

    // Reset while in SEND mid-packet; fresh arbitration afterwards
    tx_ready_i = 1'b0;
    clear_src(1); push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
    drive_srcs();
    cyc(); drive_srcs();
    cyc(); drive_srcs();
    check("mid_txv", tx_valid_o, 1'b1);
    check("mid_txd", tx_data_o, 8'h61);
    rst_i = 1'b1;
    #1;
    check("arst_txv", tx_valid_o, 1'b0);
    check("arst_grant", grant_o, 4'b0000);
    check("arst_txd", tx_data_o, 8'h00);
    cyc();
    rst_i = 1'b0;
    b = tx_log.size();
    clear_src(1);
    clear_src(3); push(3, 8'h77, 1'b1);
    tx_ready_i = 1'b1;
    drive_srcs();
    cyc(); drive_srcs();
    check("post_rst_grant", grant_o, 4'b1000);
    run_until("post_rst_done", b + 1, 10);
    repeat (5) begin cyc(); drive_srcs(); end
    check("post_rst_count", tx_log.size(), b + 1);
    check("post_rst_data", tx_log[b], 8'h77);

    // Owner stalls in HOLD; requester 0 waits behind it
    b = tx_log.size();
    r0 = ready_cnt[0];
    clear_src(1); push(1, 8'h81, 1'b0);
    drive_srcs();
    run_until("hold_first", b + 1, 10);
    check("hold_grant", grant_o, 4'b0010);
    clear_src(0); push(0, 8'h90, 1'b1);
    drive_srcs();
`ifdef UART_ARB_TIMEOUT_EN
    k_to = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_o) break;
      cyc(); drive_srcs();
      k_to++;
    end
    check("to_delay", k_to, 16);
    check("to_grant_held", grant_o, 4'b0000);
    cyc(); drive_srcs();
    check("to_pulse_end", timeout_o, 1'b0);
    check("to_next_grant", grant_o, 4'b0001);
    run_until("to_done", b + 2, 10);
    check("to_next_data", tx_log[b+1], 8'h90);
    check("to_count", to_cnt, 1);
`else
    k_to = 0;
    repeat (40) begin cyc(); drive_srcs(); end
    check("hold_locked", grant_o, 4'b0010);
    check("hold_no_steal", ready_cnt[0] - r0, 0);
    check("hold_no_to", to_cnt, k_to);
    push(1, 8'h82, 1'b1);
    drive_srcs();
    run_until("hold_done", b + 3, 20);
    check("hold_resume", tx_log[b+1], 8'h82);
    check("hold_next", tx_log[b+2], 8'h90);
`endif

    check("ready_without_valid", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
